// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the TDM receive path.
//   tdm_state_e    : framing FSM states (HUNT, COLLECT)
//   TDM_N_CH_DEF   : default number of channels per frame
//   TDM_WIDTH_DEF  : default bits per channel word
//   slot_width()   : width of the slot index for a given channel count
package tdm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_e;

  localparam int TDM_N_CH_DEF  = 4;
  localparam int TDM_WIDTH_DEF = 8;

  // Slot index width; never narrower than one bit so the counter is always a
  // real register even at the smallest legal channel count.
  function automatic int slot_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: mod-N_CH slot index for the TDM deserializer.
//   clk        : system clock
//   reset      : synchronous active-high reset (slot -> 0)
//   load_one_i : a frame start was accepted as channel 0; next slot is 1
//   clear_i    : frame completed; next slot is 0
//   incr_i     : a mid-frame beat was accepted; advance one slot
//   slot_o     : current slot index (channel expected on the next beat)
//   is_last_o  : slot_o == N_CH-1
module tdm_slot_counter #(
  parameter int N_CH = 4,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_one_i,
  input  logic          clear_i,
  input  logic          incr_i,
  output logic [CW-1:0] slot_o,
  output logic          is_last_o
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(N_CH - 1);

  logic [CW-1:0] slot_q;
  logic [CW-1:0] slot_d;

  // load_one wins: a sync beat always restarts the frame, whatever else the
  // datapath would have done with that beat.
  always_comb begin
    slot_d = slot_q;
    if (load_one_i) begin
      slot_d = CW'(1);
    end else if (clear_i) begin
      slot_d = '0;
    end else if (incr_i) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o    = slot_q;
  assign is_last_o = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer / deserializer.
// Collects N_CH consecutive valid beats (channel 0 flagged by frame_sync) into
// a shadow buffer and publishes the whole frame on dout in a single edge.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   din_valid  : qualifies din and frame_sync
//   din        : serial channel word
//   frame_sync : current beat is channel 0
//   dout       : frame, channel k at dout[k*WIDTH +: WIDTH]
//   dout_valid : one-cycle pulse when dout has just been updated
//   locked     : FSM is in COLLECT
//   sync_err   : one-cycle pulse on a framing violation
//   frame_cnt  : frames delivered, wraps at 256
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH_DEF,
  parameter int WIDTH = TDM_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din_valid,
  input  logic [WIDTH-1:0]        din,
  input  logic                    frame_sync,
  output logic [N_CH*WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    locked,
  output logic                    sync_err,
  output logic [7:0]              frame_cnt
);

  localparam int CW = slot_width(N_CH);

  tdm_state_e              state_q;
  logic [WIDTH-1:0]        shadow_q [N_CH-1];
  logic [N_CH*WIDTH-1:0]   dout_q;
  logic                    dout_valid_q;
  logic                    locked_q;
  logic                    sync_err_q;
  logic [7:0]              frame_cnt_q;

  logic [CW-1:0]           slot;
  logic                    is_last;
  logic                    in_collect;
  logic                    load_one;
  logic                    clear_slot;
  logic                    incr_slot;
  logic [N_CH*WIDTH-1:0]   frame_word;

  assign in_collect = (state_q == COLLECT);

  // Slot control mirrors the FSM below: any sync beat restarts at slot 1;
  // a non-sync beat in COLLECT either completes the frame or advances.
  // A non-sync beat at slot 0 is an error and leaves slot at 0.
  assign load_one   = din_valid & frame_sync;
  assign clear_slot = din_valid & ~frame_sync & in_collect & is_last;
  assign incr_slot  = din_valid & ~frame_sync & in_collect & ~is_last &
                      (slot != '0);

  tdm_slot_counter #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_slot_counter (
    .clk        (clk),
    .reset      (reset),
    .load_one_i (load_one),
    .clear_i    (clear_slot),
    .incr_i     (incr_slot),
    .slot_o     (slot),
    .is_last_o  (is_last)
  );

  // Completed frame: shadow holds channels 0..N_CH-2, the final channel is
  // taken straight from din so the frame lands in the same edge as the last
  // beat.
  generate
    for (genvar gi = 0; gi < N_CH - 1; gi++) begin : g_frame
      assign frame_word[gi*WIDTH +: WIDTH] = shadow_q[gi];
    end
  endgenerate
  assign frame_word[(N_CH-1)*WIDTH +: WIDTH] = din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      for (int i = 0; i < N_CH - 1; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          HUNT: begin
            // Unsynchronised beats are silently dropped while hunting.
            if (frame_sync) begin
              shadow_q[0] <= din;
              state_q     <= COLLECT;
              locked_q    <= 1'b1;
            end
          end
          COLLECT: begin
            if (frame_sync) begin
              // A sync anywhere but slot 0 abandons the partial frame; the
              // beat itself becomes the new channel 0.
              shadow_q[0] <= din;
              if (slot != '0) begin
                sync_err_q <= 1'b1;
              end
            end else if (slot == '0) begin
              // Expected a frame start and did not get one: lose lock.
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              locked_q   <= 1'b0;
            end else if (is_last) begin
              dout_q       <= frame_word;
              dout_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
            end else begin
              for (int i = 1; i < N_CH - 1; i++) begin
                if (slot == CW'(i)) begin
                  shadow_q[i] <= din;
                end
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector table plus randomized traffic checked against
// a queue-based frame model.
module tb_tdm_demux;

  localparam int NC = 4;
  localparam int W  = 8;

  logic            clk;
  logic            reset;
  logic            din_valid;
  logic [W-1:0]    din;
  logic            frame_sync;
  logic [NC*W-1:0] dout;
  logic            dout_valid;
  logic            locked;
  logic            sync_err;
  logic [7:0]      frame_cnt;

  tdm_demux #(
    .N_CH  (NC),
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din        (din),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              rst;
    bit              vld;
    bit              fs;
    logic [W-1:0]    d;
    logic [NC*W-1:0] e_dout;
    bit              e_dv;
    bit              e_lock;
    bit              e_err;
    logic [7:0]      e_cnt;
  } vec_t;

  vec_t vq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the frame in progress is a queue of accepted words.
  logic [W-1:0]    part[$];
  bit              m_locked;
  logic [NC*W-1:0] m_dout;
  bit              m_dv;
  bit              m_err;
  int              m_cnt;

  task automatic add(bit r, bit v, bit f, logic [W-1:0] d,
                     logic [NC*W-1:0] e_dout, bit e_dv, bit e_lock,
                     bit e_err, logic [7:0] e_cnt);
    vec_t x;
    x.rst = r; x.vld = v; x.fs = f; x.d = d;
    x.e_dout = e_dout; x.e_dv = e_dv; x.e_lock = e_lock;
    x.e_err = e_err; x.e_cnt = e_cnt;
    vq.push_back(x);
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic model_update(bit r, bit v, bit f, logic [W-1:0] d);
    if (r) begin
      part.delete();
      m_locked = 0; m_dout = '0; m_dv = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_dv = 0;
      m_err = 0;
      if (v) begin
        if (f) begin
          if (m_locked && part.size() != 0) m_err = 1;
          part.delete();
          part.push_back(d);
          m_locked = 1;
        end else if (m_locked) begin
          if (part.size() == 0) begin
            m_err = 1;
            m_locked = 0;
          end else begin
            part.push_back(d);
            if (part.size() == NC) begin
              for (int k = 0; k < NC; k++) m_dout[k*W +: W] = part[k];
              m_dv = 1;
              m_cnt = (m_cnt + 1) % 256;
              part.delete();
            end
          end
        end
      end
    end
  endtask

  // Drive one cycle, let the edge happen, then update the model.
  task automatic step(bit r, bit v, bit f, logic [W-1:0] d);
    reset = r; din_valid = v; frame_sync = f; din = d;
    @(posedge clk);
    #1;
    model_update(r, v, f, d);
  endtask

  initial begin
    int pos;
    bit r, v, f;
    logic [W-1:0] d;

    reset = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = '0;

    // rst vld fs din   dout         dv lk er cnt
    add(1, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'd0);
    // beats without sync after reset
    add(0, 1, 0, 8'hFF, 32'h0,        0, 0, 0, 8'd0);
    add(0, 1, 0, 8'hFF, 32'h0,        0, 0, 0, 8'd0);
    add(0, 1, 0, 8'hFF, 32'h0,        0, 0, 0, 8'd0);
    // first frame
    add(0, 1, 1, 8'h11, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h22, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h33, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h44, 32'h44332211, 1, 1, 0, 8'd1);
    add(0, 0, 0, 8'h00, 32'h44332211, 0, 1, 0, 8'd1);
    // two frames with idle gaps (one gap carries a stray sync)
    add(0, 1, 1, 8'h10, 32'h44332211, 0, 1, 0, 8'd1);
    add(0, 0, 0, 8'h5A, 32'h44332211, 0, 1, 0, 8'd1);
    add(0, 1, 0, 8'h11, 32'h44332211, 0, 1, 0, 8'd1);
    add(0, 1, 0, 8'h12, 32'h44332211, 0, 1, 0, 8'd1);
    add(0, 0, 0, 8'h00, 32'h44332211, 0, 1, 0, 8'd1);
    add(0, 1, 0, 8'h13, 32'h13121110, 1, 1, 0, 8'd2);
    add(0, 1, 1, 8'hA0, 32'h13121110, 0, 1, 0, 8'd2);
    add(0, 1, 0, 8'hA1, 32'h13121110, 0, 1, 0, 8'd2);
    add(0, 0, 1, 8'hEE, 32'h13121110, 0, 1, 0, 8'd2);
    add(0, 1, 0, 8'hA2, 32'h13121110, 0, 1, 0, 8'd2);
    add(0, 1, 0, 8'hA3, 32'hA3A2A1A0, 1, 1, 0, 8'd3);
    // early sync mid-frame
    add(0, 1, 1, 8'h11, 32'hA3A2A1A0, 0, 1, 0, 8'd3);
    add(0, 1, 0, 8'h22, 32'hA3A2A1A0, 0, 1, 0, 8'd3);
    add(0, 1, 1, 8'h55, 32'hA3A2A1A0, 0, 1, 1, 8'd3);
    add(0, 1, 0, 8'h66, 32'hA3A2A1A0, 0, 1, 0, 8'd3);
    add(0, 1, 0, 8'h77, 32'hA3A2A1A0, 0, 1, 0, 8'd3);
    add(0, 1, 0, 8'h88, 32'h88776655, 1, 1, 0, 8'd4);
    // missing sync, then re-lock
    add(0, 1, 0, 8'h99, 32'h88776655, 0, 0, 1, 8'd4);
    add(0, 1, 1, 8'h01, 32'h88776655, 0, 1, 0, 8'd4);
    add(0, 1, 0, 8'h02, 32'h88776655, 0, 1, 0, 8'd4);
    add(0, 1, 0, 8'h03, 32'h88776655, 0, 1, 0, 8'd4);
    add(0, 1, 0, 8'h04, 32'h04030201, 1, 1, 0, 8'd5);
    // early sync landing on the last slot
    add(0, 1, 1, 8'h21, 32'h04030201, 0, 1, 0, 8'd5);
    add(0, 1, 0, 8'h22, 32'h04030201, 0, 1, 0, 8'd5);
    add(0, 1, 0, 8'h23, 32'h04030201, 0, 1, 0, 8'd5);
    add(0, 1, 1, 8'h31, 32'h04030201, 0, 1, 1, 8'd5);
    add(0, 1, 0, 8'h32, 32'h04030201, 0, 1, 0, 8'd5);
    add(0, 1, 0, 8'h33, 32'h04030201, 0, 1, 0, 8'd5);
    add(0, 1, 0, 8'h34, 32'h34333231, 1, 1, 0, 8'd6);
    // reset mid-frame (reset beats a valid beat), then a fresh frame
    add(0, 1, 1, 8'h0A, 32'h34333231, 0, 1, 0, 8'd6);
    add(0, 1, 0, 8'h0B, 32'h34333231, 0, 1, 0, 8'd6);
    add(1, 1, 0, 8'h0C, 32'h0,        0, 0, 0, 8'd0);
    add(0, 1, 1, 8'h0A, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h0B, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h0C, 32'h0,        0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h0D, 32'h0D0C0B0A, 1, 1, 0, 8'd1);
    add(0, 0, 0, 8'h00, 32'h0D0C0B0A, 0, 1, 0, 8'd1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].vld, vq[i].fs, vq[i].d);
      $display("vec %0d: rst=%0d vld=%0d fs=%0d din=%h -> dout=%h dv=%0d lock=%0d err=%0d cnt=%0d",
               i, vq[i].rst, vq[i].vld, vq[i].fs, vq[i].d,
               dout, dout_valid, locked, sync_err, frame_cnt);
      check($sformatf("vec%0d dout", i), 64'(dout), 64'(vq[i].e_dout));
      check($sformatf("vec%0d dout_valid", i), 64'(dout_valid), 64'(vq[i].e_dv));
      check($sformatf("vec%0d locked", i), 64'(locked), 64'(vq[i].e_lock));
      check($sformatf("vec%0d sync_err", i), 64'(sync_err), 64'(vq[i].e_err));
      check($sformatf("vec%0d frame_cnt", i), 64'(frame_cnt), 64'(vq[i].e_cnt));
    end

    // Randomized traffic: mostly well-framed, with flipped syncs, idle
    // cycles and occasional resets.
    pos = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      f = (pos == 0);
      if ($urandom_range(0, 19) == 0) f = ~f;
      if ($urandom_range(0, 9) == 0) f = 1'($urandom);
      d = W'($urandom);
      step(r, v, f, d);
      if (r) pos = 0;
      else if (v) pos = f ? 1 : (pos + 1) % NC;
      check("rnd dout", 64'(dout), 64'(m_dout));
      check("rnd dout_valid", 64'(dout_valid), 64'(m_dv));
      check("rnd locked", 64'(locked), 64'(m_locked));
      check("rnd sync_err", 64'(sync_err), 64'(m_err));
      check("rnd frame_cnt", 64'(frame_cnt), 64'(m_cnt[7:0]));
      if (m_dv || m_err)
        $display("rnd %0d: dout=%h dv=%0d err=%0d cnt=%0d", n, dout,
                 dout_valid, sync_err, frame_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer and deserializer. It is the receive end of the team's selector datapath.
- It takes one WIDTH-bit stream in which consecutive valid beats carry channels 0..N_CH-1 in order, delimited by frame_sync.
- It reassembles each frame into N_CH parallel channel words and presents them atomically with a one-cycle dout_valid pulse.
- It sits downstream of the mux-based channel selector and feeds per-channel logic.

Parameters:
- N_CH, 4, number of channels per frame (legal range 2..16).
- WIDTH, 8, bits per channel word.
- CW, $clog2(N_CH), width of slot counter (localparam, derived).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din_valid  input  1  din and frame_sync are sampled only when high.
- din  input  WIDTH  serial channel word.
- frame_sync  input  1  qualified by din_valid; marks the current beat as channel 0.
- dout  output  N_CH*WIDTH  channel k at dout[k*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse when dout has just been updated with a complete frame.
- locked  output  1  high while the FSM is in COLLECT.
- sync_err  output  1  one-cycle pulse on a framing violation.
- frame_cnt  output  8  count of complete frames delivered; wraps 255->0.

Behaviour:
- Reset (reset=1 at clock edge):
  - state=HUNT, slot=0, shadow buffer=0.
  - dout=0, dout_valid=0, locked=0, sync_err=0, frame_cnt=0.
  - Reset has priority over every input. Reset mid-frame discards the partial frame; dout keeps no old data (cleared).
- FSM states: HUNT, COLLECT. locked is registered and equals (state==COLLECT).
- Beat = cycle with din_valid=1. Cycles with din_valid=0 change nothing; frame_sync is ignored when din_valid=0.
- HUNT:
  - Beat with frame_sync=1: shadow[0]<=din, slot<=1, go COLLECT.
  - Beat with frame_sync=0: dropped, no error, stay HUNT.
- COLLECT, slot==0 (expecting a frame start):
  - Beat with frame_sync=1: shadow[0]<=din, slot<=1.
  - Beat with frame_sync=0: sync_err pulse, beat dropped, go HUNT.
- COLLECT, 0<slot<N_CH-1:
  - Beat with frame_sync=0: shadow[slot]<=din, slot<=slot+1.
  - Beat with frame_sync=1 (early sync): sync_err pulse, partial frame discarded, beat accepted as new channel 0 (shadow[0]<=din, slot<=1), stay COLLECT.
- COLLECT, slot==N_CH-1:
  - Beat with frame_sync=0 (last beat): dout<={din, shadow[N_CH-2:0]} in one edge, dout_valid<=1, frame_cnt<=frame_cnt+1, slot<=0.
  - Beat with frame_sync=1: treated as early sync (same as above); no frame delivered.
- Latency: dout/dout_valid assert on the clock edge that samples the last beat, i.e. visible in the next cycle.
- Back-to-back frames at full rate yield dout_valid once every N_CH cycles.
- dout holds its value between frames and never shows a partially updated frame.
- dout_valid and sync_err are never high in the same cycle.
- sync_err is a single-cycle registered pulse per violation.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, COLLECT}.
  - Default N_CH and WIDTH constants.
  - Helper function for the slot-index width.
- One natural sub-module, tdm_slot_counter: a mod-N_CH counter with load-to-1, clear and increment, plus an is_last flag.
- Shadow buffer and FSM live in tdm_demux.

Test Plan (N_CH=4, WIDTH=8):
- Reset, then frame: 4 beats 0x11(sync),0x22,0x33,0x44 -> next cycle dout=0x44332211, dout_valid=1 for exactly 1 cycle, frame_cnt=1, locked=1.
- Two back-to-back frames, second 0xA0..0xA3, with din_valid=0 gaps inserted mid-frame -> dout=0xA3A2A1A0 once, gaps ignored, frame_cnt=2, no sync_err.
- Early sync: 0x11(sync),0x22,0x55(sync),0x66,0x77,0x88 -> sync_err pulse after the 3rd beat; dout=0x88776655; old partial frame never appears.
- Missing sync after a complete frame: next beat 0x99 with frame_sync=0 -> sync_err pulse, locked=0, beat dropped. A following sync frame 0x01..0x04 re-locks and delivers 0x04030201.
- Beats without sync after reset (0xFF x3) -> no output, no sync_err, locked stays 0.
- Reset asserted after 2 beats of a frame -> all outputs 0 next cycle. Then a full frame 0x0A..0x0D -> dout=0x0D0C0B0A, frame_cnt=1.
